// File: rtl/video_port_decoder.sv
// video_port_decoder: decodes Z80 I/O writes into single-cycle register strobes.
//
// Ports:
//   clk, res_n            clock, asynchronous active-low reset
//   a[15:0], di[7:0]      Z80 address/data bus (already synchronous to clk)
//   iorq_n, wr_n, m1_n    Z80 control; an I/O write is !iorq_n & !wr_n & m1_n
//   d[7:0]                data byte captured with the last accepted write
//   *_wr                  one-cycle strobes, at most one per I/O write
//   lock_7ffd             sticky #7FFD lock, cleared only by reset
//
// A write is captured on the first edge that sees io_wr, and its strobe is
// decoded purely from the captured registers during the following cycle.
// The FSM then waits for io_wr to drop, so a long I/O cycle fires only once.
module video_port_decoder (
   input  logic        clk,
   input  logic        res_n,
   input  logic [15:0] a,
   input  logic [7:0]  di,
   input  logic        iorq_n,
   input  logic        wr_n,
   input  logic        m1_n,
   output logic [7:0]  d,
   output logic        zborder_wr,
   output logic        zvpage_wr,
   output logic        vconf_wr,
   output logic        vpage_wr,
   output logic        gx_offsl_wr,
   output logic        gx_offsh_wr,
   output logic        gy_offsl_wr,
   output logic        gy_offsh_wr,
   output logic        tsconf_wr,
   output logic        palsel_wr,
   output logic        border_wr,
   output logic        t0x_offsl_wr,
   output logic        t0x_offsh_wr,
   output logic        t0y_offsl_wr,
   output logic        t0y_offsh_wr,
   output logic        t1x_offsl_wr,
   output logic        t1x_offsh_wr,
   output logic        t1y_offsl_wr,
   output logic        t1y_offsh_wr,
   output logic        tmpage_wr,
   output logic        t0gpage_wr,
   output logic        t1gpage_wr,
   output logic        sgpage_wr,
   output logic        hint_beg_wr,
   output logic        vint_begl_wr,
   output logic        vint_begh_wr,
   output logic        lock_7ffd
);

   typedef enum logic [1:0] {StIdle, StStrobe, StWait} state_e;

   state_e      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        lock_q, lock_d;

   logic io_wr;
   logic ts_hit;
   logic zvpage_hit;

   assign io_wr = ~iorq_n & ~wr_n & m1_n;

   // Decode terms use only captured state, never the live bus.
   assign ts_hit     = (addr_q[7:0] == 8'hAF);
   assign zvpage_hit = ~addr_q[15] & (addr_q[1:0] == 2'b01);

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q <= StIdle;
         addr_q  <= 16'h0000;
         data_q  <= 8'h00;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         lock_q  <= lock_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      lock_d  = lock_q;
      case (state_q)
         StIdle: begin
            if (io_wr) begin
               addr_d  = a;
               data_d  = di;
               state_d = StStrobe;
            end
         end
         StStrobe: begin
            // Strobe is committed once captured; io_wr dropping here only
            // shortens the wait.
            state_d = StWait;
            if (zvpage_wr && data_q[5]) lock_d = 1'b1;
         end
         StWait: begin
            if (!io_wr) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      zborder_wr   = 1'b0;
      zvpage_wr    = 1'b0;
      vconf_wr     = 1'b0;
      vpage_wr     = 1'b0;
      gx_offsl_wr  = 1'b0;
      gx_offsh_wr  = 1'b0;
      gy_offsl_wr  = 1'b0;
      gy_offsh_wr  = 1'b0;
      tsconf_wr    = 1'b0;
      palsel_wr    = 1'b0;
      border_wr    = 1'b0;
      t0x_offsl_wr = 1'b0;
      t0x_offsh_wr = 1'b0;
      t0y_offsl_wr = 1'b0;
      t0y_offsh_wr = 1'b0;
      t1x_offsl_wr = 1'b0;
      t1x_offsh_wr = 1'b0;
      t1y_offsl_wr = 1'b0;
      t1y_offsh_wr = 1'b0;
      tmpage_wr    = 1'b0;
      t0gpage_wr   = 1'b0;
      t1gpage_wr   = 1'b0;
      sgpage_wr    = 1'b0;
      hint_beg_wr  = 1'b0;
      vint_begl_wr = 1'b0;
      vint_begh_wr = 1'b0;
      if (state_q == StStrobe) begin
         // #FE, #7FFD and #xxAF differ in a[1:0], so the chain is exclusive.
         if (!addr_q[0]) begin
            zborder_wr = 1'b1;
         end else if (zvpage_hit) begin
            zvpage_wr = ~lock_q;
         end else if (ts_hit) begin
            case (addr_q[15:8])
               8'h00:   vconf_wr     = 1'b1;
               8'h01:   vpage_wr     = 1'b1;
               8'h02:   gx_offsl_wr  = 1'b1;
               8'h03:   gx_offsh_wr  = 1'b1;
               8'h04:   gy_offsl_wr  = 1'b1;
               8'h05:   gy_offsh_wr  = 1'b1;
               8'h06:   tsconf_wr    = 1'b1;
               8'h07:   palsel_wr    = 1'b1;
               8'h0F:   border_wr    = 1'b1;
               8'h16:   tmpage_wr    = 1'b1;
               8'h17:   t0gpage_wr   = 1'b1;
               8'h18:   t1gpage_wr   = 1'b1;
               8'h19:   sgpage_wr    = 1'b1;
               8'h22:   hint_beg_wr  = 1'b1;
               8'h23:   vint_begl_wr = 1'b1;
               8'h24:   vint_begh_wr = 1'b1;
               8'h40:   t0x_offsl_wr = 1'b1;
               8'h41:   t0x_offsh_wr = 1'b1;
               8'h42:   t0y_offsl_wr = 1'b1;
               8'h43:   t0y_offsh_wr = 1'b1;
               8'h44:   t1x_offsl_wr = 1'b1;
               8'h45:   t1x_offsh_wr = 1'b1;
               8'h46:   t1y_offsl_wr = 1'b1;
               8'h47:   t1y_offsh_wr = 1'b1;
               default: ;
            endcase
         end
      end
   end

   assign d         = data_q;
   assign lock_7ffd = lock_q;

endmodule
